// File: rtl/moody_source.sv
// Pseudo-random traffic source driving a req/busy channel with sequence-numbered items.
// Optional MOODY_SOURCE_STALL_CNT_EN adds a saturating stall_count output.
`ifndef SIZE
`define SIZE 8
`endif

module moody_source #(
   parameter int          id         = -1,
   parameter int          generosity = 0,
   parameter int unsigned max_items  = 0,
   parameter logic [7:0]  seed       = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              busy,
   output logic              req,
   output logic [`SIZE-1:0]  data,
   output logic              done
`ifdef MOODY_SOURCE_STALL_CNT_EN
   ,
   output logic [31:0]       stall_count
`endif
);

   typedef enum logic [1:0] {IDLE, OFFER, DONE} state_t;

   localparam logic [7:0] seed_init = (seed == 8'h00) ? 8'h01 : seed;
   localparam logic [8:0] threshold = (generosity >= 256) ? 9'd256 :
                                      (generosity <= 0)   ? 9'd0   : 9'(generosity);

   state_t             state, state_next;
   logic [7:0]         lfsr;
   logic [`SIZE-1:0]   seq;
   logic [31:0]        sent;
   logic [31:0]        sent_after;
   logic               decision;
   logic               transfer;
   logic               limit_hit;
   logic               req_next;
   logic               done_next;
   logic [`SIZE-1:0]   data_next;
   logic [`SIZE-1:0]   seq_next;

   assign decision   = ({1'b0, lfsr} < threshold);
   assign transfer   = (state == OFFER) && !busy;
   assign sent_after = (transfer && (sent != '1)) ? sent + 32'd1 : sent;
   // The limit check already counts a transfer happening on this same edge.
   assign limit_hit  = (max_items != 0) && (sent_after == max_items);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         lfsr  <= seed_init;
         seq   <= '0;
         sent  <= '0;
         req   <= 1'b0;
         data  <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         lfsr  <= {lfsr[6:0], ^(lfsr & 8'hB8)};
         seq   <= seq_next;
         sent  <= sent_after;
         req   <= req_next;
         data  <= data_next;
         done  <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (limit_hit)     state_next = DONE;
            else if (decision) state_next = OFFER;
         end
         OFFER: begin
            if (transfer) begin
               if (limit_hit)     state_next = DONE;
               else if (decision) state_next = OFFER;
               else               state_next = IDLE;
            end
         end
         DONE:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // A held offer keeps data untouched; a new or back-to-back offer loads the next sequence number.
   always_comb begin
      req_next  = (state_next == OFFER);
      done_next = (state_next == DONE);
      seq_next  = transfer ? seq + 1'b1 : seq;
      data_next = data;
      if ((state == IDLE) && (state_next == OFFER))
         data_next = seq;
      else if (transfer && (state_next == OFFER))
         data_next = seq + 1'b1;
   end

`ifdef MOODY_SOURCE_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         stall_count <= '0;
      else if (req && busy && (stall_count != '1))
         stall_count <= stall_count + 32'd1;
   end
`endif

endmodule
